// File: rtl/ps2_receive.sv
// PS/2 device-to-host frame receiver: synchronize, filter, decode start/8 data/odd parity/stop.
// Optional frame watchdog enabled by defining PS2_RX_TIMEOUT_EN.
module ps2_receive #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic       qzt_clk,
    input  logic       reset,
    input  logic       PS2C,
    input  logic       PS2D,
    input  logic       inhibit,
    output logic [7:0] data,
    output logic       valid,
    output logic       err,
    output logic [1:0] err_code,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } state_t;

    localparam logic [7:0] FILT_LAST = 8'(FILTER_LEN - 1);

    logic [1:0] c_sync, d_sync;
    logic [7:0] c_cnt, d_cnt;
    logic       c_filt, d_filt, c_filt_q;
    logic       fall;

    state_t     state, state_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [7:0] shreg, shreg_n;
    logic       par_q, par_n;
    logic [7:0] data_n;
    logic       valid_n, err_n;
    logic [1:0] code_n;
    logic       timeout_hit;

    // Two-flop synchronizers followed by run-length stability filters.
    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            c_sync   <= 2'b11;
            d_sync   <= 2'b11;
            c_cnt    <= 8'd0;
            d_cnt    <= 8'd0;
            c_filt   <= 1'b1;
            d_filt   <= 1'b1;
            c_filt_q <= 1'b1;
        end else begin
            c_sync   <= {c_sync[0], PS2C};
            d_sync   <= {d_sync[0], PS2D};
            c_filt_q <= c_filt;
            if (c_sync[1] == c_filt) begin
                c_cnt <= 8'd0;
            end else if (c_cnt == FILT_LAST) begin
                c_filt <= c_sync[1];
                c_cnt  <= 8'd0;
            end else begin
                c_cnt <= c_cnt + 8'd1;
            end
            if (d_sync[1] == d_filt) begin
                d_cnt <= 8'd0;
            end else if (d_cnt == FILT_LAST) begin
                d_filt <= d_sync[1];
                d_cnt  <= 8'd0;
            end else begin
                d_cnt <= d_cnt + 8'd1;
            end
        end
    end

    assign fall = c_filt_q & ~c_filt;
    assign busy = (state != ST_IDLE);

`ifdef PS2_RX_TIMEOUT_EN
    logic [19:0] wd;
    // An edge in the limit cycle wins: the counter clears instead of firing.
    assign timeout_hit = busy && !fall && ({1'b0, wd} + 21'd1 == 21'(TIMEOUT_CYC));

    always_ff @(posedge qzt_clk) begin
        if (reset || inhibit || fall || !busy || timeout_hit) begin
            wd <= 20'd0;
        end else begin
            wd <= wd + 20'd1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge qzt_clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= 3'd0;
            shreg    <= 8'd0;
            par_q    <= 1'b0;
            data     <= 8'd0;
            valid    <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shreg    <= shreg_n;
            par_q    <= par_n;
            data     <= data_n;
            valid    <= valid_n;
            err      <= err_n;
            err_code <= code_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shreg_n   = shreg;
        par_n     = par_q;
        data_n    = data;
        valid_n   = 1'b0;
        err_n     = 1'b0;
        code_n    = err_code;
        if (inhibit) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 3'd0;
        end else if (fall) begin
            case (state)
                ST_IDLE: begin
                    if (!d_filt) begin
                        state_n   = ST_DATA;
                        bit_cnt_n = 3'd0;
                    end else begin
                        err_n  = 1'b1;
                        code_n = 2'b01;
                    end
                end
                ST_DATA: begin
                    shreg_n   = {d_filt, shreg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state_n = ST_PARITY;
                end
                ST_PARITY: begin
                    par_n   = d_filt;
                    state_n = ST_STOP;
                end
                ST_STOP: begin
                    state_n   = ST_IDLE;
                    bit_cnt_n = 3'd0;
                    // Stop-bit failure masks a parity failure.
                    if (!d_filt) begin
                        err_n  = 1'b1;
                        code_n = 2'b11;
                    end else if (!(^{shreg, par_q})) begin
                        err_n  = 1'b1;
                        code_n = 2'b10;
                    end else begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                    end
                end
                default: state_n = ST_IDLE;
            endcase
        end else if (timeout_hit) begin
            state_n   = ST_IDLE;
            bit_cnt_n = 3'd0;
            err_n     = 1'b1;
            code_n    = 2'b00;
        end
    end

endmodule

// File: tb/tb_ps2_receive.sv
// Bench for ps2_receive: table vectors, random frames against a parity/stop model, corner sequences.
module tb_ps2_receive;
  localparam int FL     = 8;
  localparam int TB_TO  = 5000;
  localparam int HP     = 30;

  logic       clk = 1'b0;
  logic       reset, ps2c, ps2d, inhibit;
  logic [7:0] data;
  logic       valid, err, busy;
  logic [1:0] err_code;

  ps2_receive #(.FILTER_LEN(FL), .TIMEOUT_CYC(TB_TO)) dut (
    .qzt_clk(clk), .reset(reset), .PS2C(ps2c), .PS2D(ps2d), .inhibit(inhibit),
    .data(data), .valid(valid), .err(err), .err_code(err_code), .busy(busy)
  );

  always #5 clk = ~clk;

  // Event word: [10] valid(1)/err(0), [9:8] code (0 for valid), [7:0] data
  logic [10:0] exp_q[$];
  int          vec_cnt  = 0;
  int          miss_cnt = 0;
  logic [7:0]  last_data = 8'h00;
  logic [1:0]  last_code = 2'b00;

  typedef struct {
    logic [7:0] d;
    logic       p;
    logic       s;
    logic       is_valid;
    logic [1:0] code;
  } vec_t;
  vec_t tbl[7];

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (valid && err) begin
        vec_cnt++; miss_cnt++;
        $display("FAIL both_pulses: valid=%0b err=%0b expected not both", valid, err);
      end else if (valid || err) begin
        logic [10:0] obs;
        obs = {valid, valid ? 2'b00 : err_code, data};
        vec_cnt++;
        if (exp_q.size() == 0) begin
          miss_cnt++;
          $display("FAIL unexpected_pulse: got %0h expected none", obs);
        end else begin
          logic [10:0] e;
          e = exp_q.pop_front();
          if (obs !== e) begin
            miss_cnt++;
            $display("FAIL pulse: got %0h expected %0h", obs, e);
          end
        end
      end
    end
  end

  function automatic void push_exp(input logic is_v, input logic [1:0] code, input logic [7:0] d);
    if (is_v) begin
      last_data = d;
      exp_q.push_back({1'b1, 2'b00, d});
    end else begin
      last_code = code;
      exp_q.push_back({1'b0, code, last_data});
    end
  endfunction

  // Frame outcome computed from the protocol rules directly.
  function automatic void model_frame(input logic [7:0] d, input logic p, input logic s);
    int ones;
    ones = $countones({d, p});
    if (!s)                push_exp(1'b0, 2'b11, d);
    else if (ones % 2 == 0) push_exp(1'b0, 2'b10, d);
    else                   push_exp(1'b1, 2'b00, d);
  endfunction

  task automatic ps2_bit(input logic b, input int hp, input bit lat, input bit glitch);
    ps2d = b;
    if (glitch) begin
      tick(hp / 2); ps2c = 1'b0; tick(3); ps2c = 1'b1; tick(hp - hp / 2 - 3);
    end else begin
      tick(hp);
    end
    ps2c = 1'b0;
    if (lat) begin
      tick(FL + 2);
      chk("pulse_early", {30'd0, valid, err}, 32'd0);
      tick(1);
      chk("pulse_latency", {31'd0, valid | err}, 32'd1);
      tick(hp - FL - 3);
    end else begin
      tick(hp);
    end
    ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int hp, input int gbit);
    ps2_bit(1'b0, hp, 1'b0, gbit == 0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i], hp, 1'b0, gbit == i + 1);
    ps2_bit(p, hp, 1'b0, 1'b0);
    ps2_bit(s, hp, 1'b1, 1'b0);
    ps2d = 1'b1;
    tick(hp);
  endtask

  initial begin
    tbl[0] = '{8'hFA, 1'b1, 1'b1, 1'b1, 2'b00};
    tbl[1] = '{8'h08, 1'b0, 1'b1, 1'b1, 2'b00};
    tbl[2] = '{8'h28, 1'b1, 1'b1, 1'b1, 2'b00};
    tbl[3] = '{8'h08, 1'b1, 1'b1, 1'b0, 2'b10};
    tbl[4] = '{8'h55, 1'b1, 1'b0, 1'b0, 2'b11};
    tbl[5] = '{8'h08, 1'b1, 1'b0, 1'b0, 2'b11};
    tbl[6] = '{8'h81, 1'b1, 1'b1, 1'b1, 2'b00};

    reset = 1'b1; ps2c = 1'b1; ps2d = 1'b1; inhibit = 1'b0;
    @(posedge clk); #1;
    tick(4);
    chk("rst_data", {24'd0, data}, 32'h00);
    chk("rst_pulses", {30'd0, valid, err}, 32'd0);
    chk("rst_code", {30'd0, err_code}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick(20);

    // Table frames; the first one uses the slow 1500-cycle half period.
    for (int i = 0; i < 7; i++) begin
      push_exp(tbl[i].is_valid, tbl[i].code, tbl[i].d);
      send_frame(tbl[i].d, tbl[i].p, tbl[i].s, (i == 0) ? 1500 : HP, -1);
      chk("busy_after_frame", {31'd0, busy}, 32'd0);
      if (i == 0) chk("data_fa", {24'd0, data}, 32'hFA);
    end
    chk("err_code_held", {30'd0, err_code}, {30'd0, last_code});

    // Glitch while idle, then a glitch inside a frame.
    ps2c = 1'b0; tick(3); ps2c = 1'b1; tick(30);
    chk("glitch_idle_busy", {31'd0, busy}, 32'd0);
    push_exp(1'b1, 2'b00, 8'h3C);
    send_frame(8'h3C, 1'b1, 1'b1, HP, 4);
    chk("glitch_mid_data", {24'd0, data}, 32'h3C);

    // Start bit high: single edge, reported and stays idle.
    push_exp(1'b0, 2'b01, 8'h00);
    ps2_bit(1'b1, HP, 1'b1, 1'b0);
    tick(HP);
    chk("start_high_busy", {31'd0, busy}, 32'd0);
    chk("start_high_code", {30'd0, err_code}, 32'd1);

    // Inhibit aborts a frame silently.
    for (int i = 0; i < 5; i++) ps2_bit((i == 0) ? 1'b0 : 1'b1, HP, 1'b0, 1'b0);
    chk("busy_mid_frame", {31'd0, busy}, 32'd1);
    inhibit = 1'b1; tick(2);
    chk("inhibit_busy", {31'd0, busy}, 32'd0);
    tick(50); inhibit = 1'b0; tick(50);
    push_exp(1'b1, 2'b00, 8'hAA);
    send_frame(8'hAA, 1'b1, 1'b1, HP, -1);
    chk("after_inhibit_data", {24'd0, data}, 32'hAA);

    // Reset mid-frame returns everything to reset values.
    for (int i = 0; i < 5; i++) ps2_bit((i == 0) ? 1'b0 : 1'b1, HP, 1'b0, 1'b0);
    reset = 1'b1; tick(2); reset = 1'b0;
    last_data = 8'h00; last_code = 2'b00;
    chk("midrst_data", {24'd0, data}, 32'h00);
    chk("midrst_code", {30'd0, err_code}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    tick(20);
    push_exp(1'b1, 2'b00, 8'h5A);
    send_frame(8'h5A, 1'b1, 1'b1, HP, -1);

`ifdef PS2_RX_TIMEOUT_EN
    // Truncated frame: start + 4 data bits, then the clock stops.
    for (int i = 0; i < 4; i++) ps2_bit((i == 0) ? 1'b0 : 1'b1, HP, 1'b0, 1'b0);
    push_exp(1'b0, 2'b00, 8'h00);
    ps2d = 1'b0; tick(HP); ps2c = 1'b0;
    tick(FL + 2 + TB_TO);
    chk("timeout_early", {31'd0, err}, 32'd0);
    tick(1);
    chk("timeout_err", {31'd0, err}, 32'd1);
    chk("timeout_code", {30'd0, err_code}, 32'd0);
    ps2c = 1'b1; ps2d = 1'b1; tick(HP);
    chk("timeout_busy", {31'd0, busy}, 32'd0);
    push_exp(1'b1, 2'b00, 8'hFA);
    send_frame(8'hFA, 1'b1, 1'b1, HP, -1);
`endif

    // Random frames against the model.
    for (int n = 0; n < 20; n++) begin
      logic [7:0] d;
      logic       p, s;
      d = 8'($urandom_range(0, 255));
      p = ~^d;
      if ($urandom_range(0, 3) == 0) p = ~p;
      s = ($urandom_range(0, 4) != 0);
      model_frame(d, p, s);
      send_frame(d, p, s, HP, -1);
    end

    tick(100);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end
endmodule

// File: doc/ps2_receive.md
# ps2_receive

Receives device-to-host PS/2 frames (start, 8 data bits LSB first, odd parity, stop) from the mouse and delivers each byte with a one-cycle valid strobe. It sits directly downstream of the PS/2 line pins, in parallel with `PS2_send`: it consumes the acknowledge byte (0xFA) and movement packets the mouse returns after each host command. It samples the bus passively and never drives PS2C or PS2D.

## Interface
- `FILTER_LEN`, default 8: number of consecutive identical synchronized samples required before a filtered line changes value (range 2..255).
- `TIMEOUT_CYC`, default 100000: maximum qzt_clk cycles between consecutive filtered PS2C falling edges inside a frame (2 ms at 50 MHz). Maximum 2^20−1.
- `qzt_clk`  in  1  system clock, 50 MHz. One clock domain only.
- `reset`  in  1  synchronous, active-high.
- `PS2C`  in  1  raw PS/2 clock line, asynchronous.
- `PS2D`  in  1  raw PS/2 data line, asynchronous.
- `inhibit`  in  1  high while the host sender owns the bus; the receiver ignores all traffic.
- `data`  out  8  last received byte, held until the next good frame.
- `valid`  out  1  one-cycle pulse: `data` has just been updated.
- `err`  out  1  one-cycle pulse: frame rejected.
- `err_code`  out  2  reason, valid with `err`: 00 timeout, 01 start bit high, 10 parity, 11 stop bit low. Held until the next `err`.
- `busy`  out  1  high while the state is not ST_IDLE.

## Operation
- Input conditioning: each line passes through a 2-FF synchronizer and then a stability filter. A filtered line changes only after `FILTER_LEN` equal consecutive samples. Reset value of both filtered lines is 1.
- A falling edge is filtered PS2C going 1→0. Filtered PS2D is sampled in the same cycle.
- States:
  - ST_IDLE: on a falling edge, a sampled 0 moves to ST_DATA with bit count 0. A sampled 1 pulses `err` with code 01 and stays in ST_IDLE.
  - ST_DATA: each edge shifts the sampled bit into bit 7 of the shift register (LSB arrives first). After the 8th bit the state moves to ST_PARITY.
  - ST_PARITY: the edge stores the parity bit and moves to ST_STOP.
  - ST_STOP: the edge samples the stop bit and the state returns to ST_IDLE.
    - Stop bit 0 → `err`, code 11.
    - Stop bit 1 and the XOR of the 8 data bits and parity bit is 0 → `err`, code 10.
    - Otherwise `data` ← shift register and `valid` pulses.
    - Stop and parity both bad → code 11 only.
- `inhibit` high: the state is forced to ST_IDLE and the bit count is cleared. No `valid` or `err` is produced. The filters keep running. A frame in progress is aborted silently.
- `valid` and `err` are never high in the same cycle.
- `reset` mid-frame: on the next edge the block is in ST_IDLE with no pulses, and all outputs are at their reset values.

## Timing
- Reset values: `data` 0x00, `valid` 0, `err` 0, `err_code` 00, `busy` 0. State ST_IDLE, counters 0.
- Latency from a raw PS2C fall to the internal edge detect: 2 sync cycles + `FILTER_LEN` cycles.
- `valid`/`err` rise on the qzt_clk edge following the stop-bit edge detect. Total from the raw stop-bit PS2C fall: `FILTER_LEN`+3 cycles.
- `busy` rises one cycle after the start-bit edge detect. It falls in the same cycle that `valid`/`err` rise.
- Pulses of less than `FILTER_LEN` cycles on either line have no effect.

## Configuration
- `PS2_RX_TIMEOUT_EN` defined:
  - A 20-bit watchdog clears on every edge detect and counts while `busy` is high.
  - When it reaches `TIMEOUT_CYC`, the next cycle pulses `err` with code 00 and returns the state to ST_IDLE.
  - An edge detect in the same cycle the limit is reached takes precedence and clears the counter.
- Not defined: no watchdog logic exists. A truncated frame waits indefinitely for further edges; only `inhibit` or `reset` clears it. Code 00 is never produced.

## Test plan
- Frame 0xFA, parity 1, stop 1, PS2 clock half-period 1500 cycles → one `valid` pulse, `data`=0xFA, `err` stays 0, `busy` low afterwards.
- Frame 0x08, parity 0, followed by frame 0x28, parity 1 → two `valid` pulses, `data` 0x08 then 0x28.
- Frame 0x08 sent with parity 1 → `err` pulse, `err_code`=10, `data` unchanged, no `valid`. A frame with stop 0 → `err_code`=11.
- 3-cycle low glitch on PS2C while idle, and again mid-bit → no state change, no pulses. Start bit 1 → `err_code`=01.
- With `PS2_RX_TIMEOUT_EN`, `TIMEOUT_CYC`=5000: stop clocking after 4 data bits → `err` with code 00 exactly 5001 cycles after the last edge detect, then a full 0xFA frame → `valid`.
- `inhibit` raised after 5 bits, then lowered, and a full 0xAA frame sent → no pulse during the abort, then `data`=0xAA. `reset` pulsed mid-frame → outputs at reset values, and the next full frame is received correctly.
